// File: rtl/lcd_pattern_streamer.sv
// RGB565 test-pattern frame generator: scans a frame in row- or column-major order
// and serialises every pixel into two bytes on a valid/ready byte stream.
module lcd_pattern_streamer #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int COL_MAJOR  = 1,
    parameter int BYTE_ORDER = 0,
    parameter int CHECK_LOG2 = 3,
    parameter int BAR_LOG2   = 6,
    parameter int SYNC_FMARK = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [15:0] color,
    input  logic        lcd_fmark,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        in_ready,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    localparam int CW = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_LOAD,
        S_BYTE0,
        S_BYTE1,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_x;
    logic [CW-1:0]   r_y;
    logic [1:0]      r_mode;
    logic [15:0]     r_color;
    logic [15:0]     r_pix;
    logic            r_fm_meta;
    logic            r_fm_sync;
    logic            r_fm_prev;

    logic            w_fm_rise;
    logic            w_last;
    logic            w_start;
    logic [CW-1:0]   w_nx;
    logic [CW-1:0]   w_ny;
    logic [15:0]     w_next_pix;
    logic [15:0]     w_first_pix;

    function automatic logic [15:0] pattern(input logic [1:0]    m,
                                            input logic [15:0]   c,
                                            input logic [CW-1:0] x,
                                            input logic [CW-1:0] y);
        logic [CW-1:0] w_xt;
        logic [CW-1:0] w_yt;
        pattern = 16'h0000;
        w_xt    = '0;
        w_yt    = '0;
        unique case (m)
            2'd0: pattern = {x[5:1], y[5:0], 5'd0};
            2'd1: pattern = c;
            2'd2: begin
                w_xt    = x >> CHECK_LOG2;
                w_yt    = y >> CHECK_LOG2;
                pattern = (w_xt[0] ^ w_yt[0]) ? 16'h0000 : c;
            end
            2'd3: begin
                w_xt = x >> BAR_LOG2;
                unique case (w_xt[2:0])
                    3'd0: pattern = 16'hFFFF;
                    3'd1: pattern = 16'hFFE0;
                    3'd2: pattern = 16'h07FF;
                    3'd3: pattern = 16'h07E0;
                    3'd4: pattern = 16'hF81F;
                    3'd5: pattern = 16'hF800;
                    3'd6: pattern = 16'h001F;
                    3'd7: pattern = 16'h0000;
                endcase
            end
        endcase
    endfunction

    function automatic logic [7:0] first_byte(input logic [15:0] p);
        return (BYTE_ORDER != 0) ? p[7:0] : p[15:8];
    endfunction

    function automatic logic [7:0] second_byte(input logic [15:0] p);
        return (BYTE_ORDER != 0) ? p[15:8] : p[7:0];
    endfunction

    // Two-flop synchroniser for the asynchronous tearing-effect input, plus an
    // edge register so a level held high only starts one frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fm_meta <= 1'b0;
            r_fm_sync <= 1'b0;
            r_fm_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge
            // value, so this chain really is three stages and not one wire.
            r_fm_meta <= lcd_fmark;
            r_fm_sync <= r_fm_meta;
            r_fm_prev <= r_fm_sync;
        end
    end

    assign w_fm_rise = r_fm_sync & ~r_fm_prev;
    assign w_last    = (r_x == CW'(H_RES - 1)) && (r_y == CW'(V_RES - 1));

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs (no latch).
        w_nx = r_x;
        w_ny = r_y;
        if (COL_MAJOR != 0) begin
            if (r_y == CW'(V_RES - 1)) begin
                w_ny = '0;
                w_nx = r_x + 1'b1;
            end else begin
                w_ny = r_y + 1'b1;
            end
        end else begin
            if (r_x == CW'(H_RES - 1)) begin
                w_nx = '0;
                w_ny = r_y + 1'b1;
            end else begin
                w_nx = r_x + 1'b1;
            end
        end
    end

    assign w_next_pix  = pattern(r_mode, r_color, w_nx, w_ny);
    assign w_first_pix = pattern(mode, color, '0, '0);

    // A back-to-back frame without fmark sync folds LOAD into DONE, leaving a
    // single bubble cycle between frames.
    assign w_start = (r_state == S_LOAD) ||
                     ((r_state == S_DONE) && enable && (SYNC_FMARK == 0));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_mode      <= 2'd0;
            r_color     <= 16'h0000;
            r_pix       <= 16'h0000;
            out_valid   <= 1'b0;
            out_data    <= 8'h00;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 16'h0000;
        end else begin
            frame_done <= 1'b0;
            if (w_start) begin
                r_mode    <= mode;
                r_color   <= color;
                r_x       <= '0;
                r_y       <= '0;
                r_pix     <= w_first_pix;
                out_valid <= 1'b1;
                out_data  <= first_byte(w_first_pix);
                busy      <= 1'b1;
                r_state   <= S_BYTE0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (enable) begin
                            if (SYNC_FMARK != 0) r_state <= S_SYNC;
                            else                 r_state <= S_LOAD;
                        end
                    end
                    S_SYNC: begin
                        if (!enable)        r_state <= S_IDLE;
                        else if (w_fm_rise) r_state <= S_LOAD;
                    end
                    S_BYTE0: begin
                        if (in_ready) begin
                            out_data <= second_byte(r_pix);
                            r_state  <= S_BYTE1;
                        end
                    end
                    S_BYTE1: begin
                        if (in_ready) begin
                            if (w_last) begin
                                out_valid   <= 1'b0;
                                out_data    <= 8'h00;
                                busy        <= 1'b0;
                                frame_done  <= 1'b1;
                                frame_count <= frame_count + 16'd1;
                                r_x         <= '0;
                                r_y         <= '0;
                                r_state     <= S_DONE;
                            end else begin
                                r_x      <= w_nx;
                                r_y      <= w_ny;
                                r_pix    <= w_next_pix;
                                out_data <= first_byte(w_next_pix);
                                r_state  <= S_BYTE0;
                            end
                        end
                    end
                    S_DONE: begin
                        if (enable && (SYNC_FMARK != 0)) r_state <= S_SYNC;
                        else                             r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
